// File: rtl/tinyalu_requester.sv
// rtl/tinyalu_requester.sv - TinyALU initiator: command stream in, start/done handshake, response stream out
module tinyalu_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [8:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_result,
  output logic [2:0] rsp_op,
  output logic       rsp_timeout,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];
  localparam logic [2:0] OP_NOP        = 3'b000;

  state_t     state_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic       alu_start_q;
  logic       rsp_valid_q;
  logic [8:0] rsp_result_q;
  logic [2:0] rsp_op_q;
  logic       rsp_timeout_q;
  logic [7:0] tocnt_q;
  logic [7:0] tocnt_d;
  logic [7:0] wait_q;
  logic [7:0] wait_d;
  logic       timeout_hit;

  // Wait-counter increment, timeout detection and saturating timeout tally
  always_comb begin
    wait_d      = wait_q + 8'd1;
    timeout_hit = (wait_d == TIMEOUT_LIMIT);
    tocnt_d     = (tocnt_q == 8'hFF) ? tocnt_q : tocnt_q + 8'd1;
  end

  // Request FSM: one outstanding command, start held until done/no_op/timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      alu_a_q       <= 8'd0;
      alu_b_q       <= 8'd0;
      alu_op_q      <= 3'd0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 9'd0;
      rsp_op_q      <= 3'd0;
      rsp_timeout_q <= 1'b0;
      tocnt_q       <= 8'd0;
      wait_q        <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_op_q    <= cmd_op;
            alu_start_q <= 1'b1;
            wait_q      <= 8'd0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          wait_q <= wait_d;
          if (alu_op_q == OP_NOP) begin
            // no_op never raises done; finish after a single start cycle
            rsp_result_q  <= 9'd0;
            rsp_timeout_q <= 1'b0;
            rsp_op_q      <= alu_op_q;
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end else if (alu_done) begin
            // done takes priority over a timeout landing on the same cycle
            rsp_result_q  <= alu_result;
            rsp_timeout_q <= 1'b0;
            rsp_op_q      <= alu_op_q;
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end else if (timeout_hit) begin
            rsp_result_q  <= 9'd0;
            rsp_timeout_q <= 1'b1;
            rsp_op_q      <= alu_op_q;
            tocnt_q       <= tocnt_d;
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          alu_start_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign alu_start     = alu_start_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign timeout_count = tocnt_q;

endmodule

// File: tb/tb_tinyalu_requester.sv
// tb/tb_tinyalu_requester.sv - randomized self-checking bench for tinyalu_requester
module tb_tinyalu_requester;

  localparam int T    = 16;
  localparam int HANG = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic [8:0] alu_result = 9'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [8:0] rsp_result;
  logic [2:0] rsp_op;
  logic       rsp_timeout;
  logic [7:0] timeout_count;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  tinyalu_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU function as the stub computes it
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [15:0] p;
    p = a * b;
    case (op)
      3'd1:    return {1'b0, a} + {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a ^ b};
      default: return p[8:0];
    endcase
  endfunction

  // Transaction-level timing: how many start cycles a command lasts and whether it times out
  function automatic bit times_out(input logic [2:0] op, input int lat);
    return (op != 3'd0) && (lat + 1 > T);
  endfunction

  function automatic int req_len(input logic [2:0] op, input int lat);
    if (op == 3'd0) return 1;
    if (lat + 1 > T) return T;
    return lat + 1;
  endfunction

  // ALU stub: raises done for one cycle after start has been seen for alu_lat+1 cycles
  int alu_lat = 1;
  int alu_cnt = 0;
  always @(negedge clk) begin
    if (alu_start === 1'b1) alu_cnt++;
    else alu_cnt = 0;
    if (alu_start === 1'b1 && alu_cnt == alu_lat + 1) begin
      alu_done   = 1'b1;
      alu_result = alu_fn(alu_a, alu_b, alu_op);
    end else begin
      alu_done   = 1'b0;
      alu_result = 9'($urandom);
    end
  end

  // Reference model: idle / requesting / responding with precomputed request length
  typedef enum int {M_IDLE, M_REQ, M_RSP} mph_t;
  mph_t       m_ph = M_IDLE;
  logic [7:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  int         m_s = 0, m_k = 0;
  bit         m_to = 0;
  logic [8:0] m_res = 0;
  int         m_tocnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph    <= M_IDLE;
      m_tocnt <= 0;
    end else begin
      case (m_ph)
        M_IDLE: if (cmd_valid) begin
          m_a  <= cmd_a;
          m_b  <= cmd_b;
          m_op <= cmd_op;
          m_s  <= req_len(cmd_op, alu_lat);
          m_to <= times_out(cmd_op, alu_lat);
          m_k  <= 0;
          m_ph <= M_REQ;
        end
        M_REQ: begin
          m_k <= m_k + 1;
          if (m_k + 1 == m_s) begin
            m_ph  <= M_RSP;
            m_res <= (m_op == 3'd0 || m_to) ? 9'd0 : alu_fn(m_a, m_b, m_op);
            if (m_to && m_tocnt != 255) m_tocnt <= m_tocnt + 1;
          end
        end
        M_RSP: if (rsp_ready) m_ph <= M_IDLE;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("cmd_ready", cmd_ready, (m_ph == M_IDLE));
      chk("alu_start", alu_start, (m_ph == M_REQ));
      chk("rsp_valid", rsp_valid, (m_ph == M_RSP));
      chk("timeout_count", timeout_count, m_tocnt);
      if (m_ph == M_REQ) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
      end
      if (m_ph == M_RSP) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_op", rsp_op, m_op);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, hold the response for 'hold' cycles, then accept it
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input int lat, input int hold,
                         output logic [8:0] res, output logic to, output int edges);
    int guard;
    alu_lat   = lat;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);
    cmd_op    = 3'($urandom);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 400) begin
      tick();
      edges++;
    end
    chk("rsp_valid_wait", rsp_valid, 1);
    res = rsp_result;
    to  = rsp_timeout;
    for (int i = 0; i < hold; i++) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [8:0] res;
  logic       to;
  int         edges;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    tick();
    checking = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_timeout_count", timeout_count, 0);

    // add with carry, one-cycle ALU
    run_cmd(8'hFF, 8'h01, 3'd1, 1, 0, res, to, edges);
    chk("add_ff_01", res, 9'h100);
    chk("add_ff_01_to", to, 0);
    chk("add_latency", edges, 2);

    // back-to-back and / xor
    run_cmd(8'hF0, 8'h3C, 3'd2, 1, 0, res, to, edges);
    chk("and_f0_3c", res, 9'h030);
    run_cmd(8'hAA, 8'h55, 3'd3, 1, 0, res, to, edges);
    chk("xor_aa_55", res, 9'h0FF);

    // no_op with ALU never done
    run_cmd(8'h12, 8'h34, 3'd0, HANG, 0, res, to, edges);
    chk("nop_result", res, 0);
    chk("nop_to", to, 0);
    chk("nop_len", edges, 1);
    chk("nop_tocnt", timeout_count, 0);

    // hung ALU -> timeout
    run_cmd(8'h01, 8'h02, 3'd1, HANG, 0, res, to, edges);
    chk("to_flag", to, 1);
    chk("to_result", res, 0);
    chk("to_len", edges, T);
    chk("to_tocnt", timeout_count, 1);

    // done coinciding with timeout: done wins
    run_cmd(8'h03, 8'h04, 3'd1, T - 1, 0, res, to, edges);
    chk("coincide_result", res, 9'h007);
    chk("coincide_to", to, 0);

    // back-pressure of 10 cycles
    run_cmd(8'h05, 8'h07, 3'd1, 1, 10, res, to, edges);
    chk("bp_add", res, 9'h00C);

    // randomized commands, latencies, back-pressure and idle gaps
    for (int n = 0; n < 80; n++) begin
      int r;
      int lat;
      r = $urandom_range(0, 9);
      if (r == 0) lat = HANG;
      else if (r == 1) lat = T - 1;
      else if (r == 2) lat = T;
      else lat = $urandom_range(1, 14);
      run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), lat,
              $urandom_range(0, 3), res, to, edges);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    // saturating timeout counter
    for (int n = 0; n < 300; n++) run_cmd(8'($urandom), 8'($urandom), 3'd1, HANG, 0, res, to, edges);
    chk("tocnt_sat", timeout_count, 255);

    // reset while in REQ
    alu_lat = HANG;
    cmd_a = 8'h09; cmd_b = 8'h09; cmd_op = 3'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_req_start", alu_start, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_req_start", alu_start, 0);
    chk("rst_req_valid", rsp_valid, 0);
    chk("rst_req_ready", cmd_ready, 1);
    chk("rst_req_tocnt", timeout_count, 0);

    // reset while in RSP
    alu_lat = 1;
    rsp_ready = 1'b0;
    cmd_a = 8'h22; cmd_b = 8'h11; cmd_op = 3'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 50) begin
      tick();
      edges++;
    end
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rsp_start", alu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ready", cmd_ready, 1);

    run_cmd(8'h01, 8'h01, 3'd1, 1, 0, res, to, edges);
    chk("post_rst_add", res, 9'h002);
    chk("post_rst_to", to, 0);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
